exp8_driver: RTL and testbench

Symbol driver for the two-input Exp8 sequence FSM, which has inputs w/x and outputs y/z. It takes 2-bit symbols from an upstream valid/ready stream and presents them on w/x only when the FSM is in an input-sampling state. It keeps a shadow copy of the FSM state and checks the returned y/z against it. Because the FSM has no reset, the block first drives a sync sequence to align with it. It sits between the stimulus source and the FSM, as the initiator end of the w/x → y/z link.

---
 rtl/exp8_driver.sv | 128 ++++++++++++
 tb/tb_exp8_driver.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/exp8_driver.sv
// Symbol driver for the Exp8 sequence FSM: syncs to the reset-less FSM, feeds
// upstream symbols only in sampling states, and checks returned y/z against a shadow.
module exp8_driver #(
  parameter int CNT_W        = 16,
  parameter int SYNC_TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  input  logic [1:0]       s_data,
  output logic             s_ready,
  output logic             w,
  output logic             x,
  input  logic             y,
  input  logic             z,
  output logic             locked,
  output logic             err,
  output logic             tmo,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] sym_cnt
);

  localparam int SC_W = (SYNC_TIMEOUT > 2) ? $clog2(SYNC_TIMEOUT) : 1;
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(SYNC_TIMEOUT - 1);

  typedef enum logic { SYNC, RUN } phase_t;
  typedef enum logic [2:0] {
    ST_A = 3'd0, ST_B = 3'd1, ST_C = 3'd2, ST_D = 3'd3,
    ST_E = 3'd4, ST_F = 3'd5, ST_G = 3'd6, ST_H = 3'd7
  } st_t;

  phase_t          phase;
  st_t             shadow;
  logic [1:0]      exp_yz;
  logic [SC_W-1:0] sync_cnt;
  logic [1:0]      wx;
  logic [1:0]      yz;

  function automatic st_t next_state(input st_t s, input logic [1:0] in);
    st_t n;
    n = ST_A;
    case (s)
      ST_A: case (in)
              2'b00:   n = ST_A;
              2'b01:   n = ST_B;
              2'b10:   n = ST_C;
              default: n = ST_D;
            endcase
      ST_B: case (in)
              2'b00:   n = ST_B;
              2'b01:   n = ST_C;
              2'b10:   n = ST_H;
              default: n = ST_E;
            endcase
      ST_C: case (in)
              2'b00:   n = ST_C;
              2'b01:   n = ST_H;
              2'b10:   n = ST_G;
              default: n = ST_F;
            endcase
      ST_F:    n = ST_D;
      ST_H:    n = ST_A;
      default: n = ST_H;  // D, E, G
    endcase
    return n;
  endfunction

  function automatic logic [1:0] out_yz(input st_t s);
    logic [1:0] o;
    case (s)
      ST_A, ST_B, ST_C: o = 2'b11;
      ST_D, ST_F:       o = 2'b10;
      ST_E, ST_G:       o = 2'b01;
      default:          o = 2'b00;
    endcase
    return o;
  endfunction

  assign yz     = {y, z};
  assign locked = (phase == RUN);

  // Symbols pass only in A/B/C; elsewhere 00 keeps the FSM on its fixed path.
  always_comb begin
    s_ready = (phase == RUN) && (shadow inside {ST_A, ST_B, ST_C});
    wx      = 2'b11;
    if (phase == RUN) wx = (s_ready && s_valid) ? s_data : 2'b00;
  end

  assign w = wx[1];
  assign x = wx[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase     <= SYNC;
      shadow    <= ST_A;
      exp_yz    <= 2'b11;
      err       <= 1'b0;
      tmo       <= 1'b0;
      frame_cnt <= '0;
      sym_cnt   <= '0;
      sync_cnt  <= '0;
    end else if (phase == SYNC) begin
      // y/z == 00 means the FSM just left H and sits in A, consuming our 11.
      if (yz == 2'b00) begin
        phase    <= RUN;
        shadow   <= ST_D;
        exp_yz   <= 2'b11;
        sync_cnt <= '0;
      end else if (sync_cnt == SC_LAST) begin
        tmo      <= 1'b1;
        sync_cnt <= '0;
      end else begin
        sync_cnt <= sync_cnt + SC_W'(1);
      end
    end else begin
      if (s_ready && s_valid) sym_cnt <= sym_cnt + CNT_W'(1);
      if (shadow == ST_H) frame_cnt <= frame_cnt + CNT_W'(1);
      if (yz != exp_yz) begin
        err   <= 1'b1;
        phase <= SYNC;
      end else begin
        shadow <= next_state(shadow, wx);
        exp_yz <= out_yz(shadow);
      end
    end
  end

endmodule

// File: tb/tb_exp8_driver.sv
// Bench for exp8_driver: an Exp8 FSM plant closes the loop, a reference model
// predicts every output each cycle, and directed checks pin key literals.
module tb_exp8_driver;
  localparam int CNT_W = 16;
  localparam int SYNC_TIMEOUT = 8;

  logic clk, rst, s_valid, s_ready, w, x, y, z, locked, err, tmo;
  logic [1:0] s_data;
  logic [CNT_W-1:0] frame_cnt, sym_cnt;

  exp8_driver #(.CNT_W(CNT_W), .SYNC_TIMEOUT(SYNC_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .w(w), .x(x), .y(y), .z(z), .locked(locked), .err(err), .tmo(tmo),
    .frame_cnt(frame_cnt), .sym_cnt(sym_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // State letters A..H as 0..7.
  function automatic int nxt(input int s, input int in);
    int t [3][4] = '{'{0, 1, 2, 3}, '{1, 2, 7, 4}, '{2, 7, 6, 5}};
    if (s < 3) return t[s][in];
    if (s == 5) return 3;
    if (s == 7) return 0;
    return 7;
  endfunction

  function automatic int outv(input int s);
    int o [8] = '{3, 3, 3, 2, 1, 2, 1, 0};
    return o[s];
  endfunction

  // FSM plant (no reset; preset only for the opening scenario).
  logic preset_en, tie, inv;
  int   p_st, p_yz;
  always @(posedge clk) begin
    if (preset_en) begin
      p_st <= 2;
      p_yz <= 3;
    end else begin
      p_st <= nxt(p_st, {30'd0, w, x});
      p_yz <= outv(p_st);
    end
  end
  assign y = tie ? 1'b1 : (p_yz[1] ^ inv);
  assign z = tie ? 1'b1 : p_yz[0];

  // Reference model of the driver.
  logic m_run, m_err, m_tmo;
  int   m_sh, m_exp, m_scnt, m_fc, m_sc;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run <= 0; m_err <= 0; m_tmo <= 0;
      m_sh <= 0; m_exp <= 3; m_scnt <= 0; m_fc <= 0; m_sc <= 0;
    end else if (!m_run) begin
      if ({y, z} == 2'b00) begin
        m_run <= 1; m_sh <= 3; m_exp <= 3; m_scnt <= 0;
      end else if (m_scnt + 1 == SYNC_TIMEOUT) begin
        m_tmo <= 1; m_scnt <= 0;
      end else m_scnt <= m_scnt + 1;
    end else begin
      int in;
      bit acc;
      acc = (m_sh < 3) && s_valid;
      in  = acc ? int'(s_data) : 0;
      if (acc) m_sc <= (m_sc + 1) % (1 << CNT_W);
      if (m_sh == 7) m_fc <= (m_fc + 1) % (1 << CNT_W);
      if (int'({y, z}) != m_exp) begin
        m_err <= 1; m_run <= 0;
      end else begin
        m_sh <= nxt(m_sh, in); m_exp <= outv(m_sh);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    bit rdy;
    int ewx;
    rdy = m_run && (m_sh < 3);
    ewx = !m_run ? 3 : ((rdy && s_valid) ? int'(s_data) : 0);
    chk("s_ready", int'(s_ready), int'(rdy));
    chk("wx", int'({w, x}), ewx);
    chk("locked", int'(locked), int'(m_run));
    chk("err", int'(err), int'(m_err));
    chk("tmo", int'(tmo), int'(m_tmo));
    chk("frame_cnt", int'(frame_cnt), m_fc);
    chk("sym_cnt", int'(sym_cnt), m_sc);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  task automatic wait_ready();
    for (int n = 0; n < 20 && !s_ready; n++) tick();
    chk("ready_wait", int'(s_ready), 1);
  endtask

  task automatic send(input logic [1:0] d);
    chk("ready_before_send", int'(s_ready), 1);
    s_valid = 1'b1; s_data = d;
    tick();
    s_valid = 1'b0; s_data = 2'b00;
  endtask

  task automatic wait_lock(input int lim);
    for (int n = 0; n < lim && !locked; n++) tick();
    chk("relock", int'(locked), 1);
  endtask

  initial begin
    int seq [4] = '{3, 2, 2, 0};
    int lows;
    rst = 1; preset_en = 1; tie = 0; inv = 0; s_valid = 0; s_data = 2'b00;
    tick();
    chk("rst_wx", int'({w, x}), 3);
    chk("rst_ready", int'(s_ready), 0);
    chk("rst_cnt", int'(sym_cnt) + int'(frame_cnt), 0);
    preset_en = 0; rst = 0;

    // Sync from C: y/z 11,10,10,00 then lock on the 5th edge.
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("sync_yz", int'({y, z}), seq[k]);
    end
    chk("unlocked_4", int'(locked), 0);
    tick();
    chk("locked_5", int'(locked), 1);
    chk("tmo_5", int'(tmo), 0);

    // Lock path D->H->A completes one frame.
    wait_ready();
    chk("fc_after_lock", int'(frame_cnt), 1);
    send(2'b01); send(2'b01); send(2'b11);
    lows = 0;
    while (!s_ready && lows < 10) begin lows++; tick(); end
    chk("ready_low_cycles", lows, 3);
    chk("fc_frame", int'(frame_cnt), 2);
    chk("sc_frame", int'(sym_cnt), 3);

    // Idle in B.
    send(2'b01);
    for (int k = 0; k < 10; k++) tick();
    chk("idle_yz", int'({y, z}), 3);
    chk("idle_err", int'(err), 0);
    chk("idle_sc", int'(sym_cnt), 4);
    chk("idle_fc", int'(frame_cnt), 2);

    // One-cycle y corruption.
    inv = 1;
    tick();
    inv = 0;
    chk("mm_err", int'(err), 1);
    chk("mm_locked", int'(locked), 0);
    chk("mm_ready", int'(s_ready), 0);
    chk("mm_wx", int'({w, x}), 3);
    wait_lock(5);
    chk("err_sticky", int'(err), 1);

    // Reset while shadow is D.
    wait_ready();
    send(2'b11);
    chk("sc_pre_rst", int'(sym_cnt), 5);
    rst = 1;
    #1;
    chk("ar_locked", int'(locked), 0);
    chk("ar_err", int'(err), 0);
    chk("ar_cnt", int'(sym_cnt) + int'(frame_cnt), 0);
    chk("ar_ready", int'(s_ready), 0);
    chk("ar_wx", int'({w, x}), 3);
    tick();
    rst = 0;
    wait_lock(8);

    // Sync timeout with y/z stuck at 11.
    tie = 1; rst = 1;
    tick();
    rst = 0;
    for (int k = 0; k < 7; k++) tick();
    chk("tmo_7", int'(tmo), 0);
    tick();
    chk("tmo_8", int'(tmo), 1);
    chk("tmo_locked", int'(locked), 0);
    chk("tmo_wx", int'({w, x}), 3);
    for (int k = 0; k < 10; k++) tick();
    tie = 0;
    wait_lock(8);
    chk("tmo_sticky", int'(tmo), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
